// File: rtl/mult_div_ctrl.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// One radix-2 step per cycle on operand magnitudes, sign fix-up in a final cycle.
module mult_div_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [31:0] opb_q, opb_d;
  logic        isdiv_q, isdiv_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;

  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] msum, dsh, ddiff;
  logic [63:0] prod, prod_neg;

  assign signed_op = ~OP[0];
  assign a_neg     = signed_op & A[31];
  assign b_neg     = signed_op & B[31];
  assign a_mag     = a_neg ? (~A + 32'd1) : A;
  assign b_mag     = b_neg ? (~B + 32'd1) : B;

  // Multiply: {acc_hi, acc_lo} holds partial product above the unconsumed multiplier bits.
  assign msum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign dsh      = {acc_hi_q, acc_lo_q[31]};
  assign ddiff    = dsh - {1'b0, opb_q};
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_neg = ~prod + 64'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    isdiv_d  = isdiv_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        dz_d    = 1'b0;
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          isdiv_d = OP[1];
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          cnt_d   = 5'd0;
          if (OP[1] && (B == 32'd0)) begin
            // Divide by zero completes immediately and leaves HI/LO alone.
            state_d = StDone;
            dz_d    = 1'b1;
          end else begin
            state_d  = StCalc;
            opb_d    = OP[1] ? b_mag : a_mag;
            acc_hi_d = 32'd0;
            acc_lo_d = OP[1] ? a_mag : b_mag;
          end
        end
      end
      StCalc: begin
        if (isdiv_q) begin
          if (!ddiff[32]) begin
            acc_hi_d = ddiff[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_d = dsh[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
          end
        end else begin
          acc_hi_d = msum[32:1];
          acc_lo_d = {msum[0], acc_lo_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFix;
      end
      StFix: begin
        if (isdiv_q) begin
          lo_d = neg_q  ? (~acc_lo_q + 32'd1) : acc_lo_q;
          hi_d = rneg_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod;
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      opb_q    <= 32'd0;
      isdiv_q  <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      isdiv_q  <= isdiv_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign busy     = (state_q == StCalc) || (state_q == StFix);
  assign done     = (state_q == StDone);
  assign div_zero = (state_q == StDone) && dz_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: directed cases then random operations, checked against
// a reference model built on plain 64-bit arithmetic.
module tb_mult_div_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  OP = 2'd0;
  logic [31:0] A = 32'd0, B = 32'd0, wdata = 32'd0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] HI, LO;
  logic        busy, done, div_zero;

  int unsigned n_cmp = 0, n_bad = 0;
  logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;

  mult_div_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .OP       (OP),
    .A        (A),
    .B        (B),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .HI       (HI),
    .LO       (LO),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] status();
    return {29'd0, busy, done, div_zero};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact products and truncating division straight from the arithmetic rules.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint          sa, sb, q, r;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h  = 32'd0;
    l  = 32'd0;
    case (op)
      2'd0: begin q = sa * sb; {h, l} = q; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; {h, l} = p; end
      2'd2: if (b != 32'd0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      default: if (b != 32'd0) begin l = a / b; h = a % b; end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op (optionally with a same-edge HI/LO write) and returns sampled in DONE.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic whi, input logic wlo, input logic [31:0] wd, input bit junk);
    logic [31:0] rh, rl;
    bit          dz;
    dz = op[1] && (b == 32'd0);
    model(op, a, b, rh, rl);
    start = 1'b1; OP = op; A = a; B = b; hi_we = whi; lo_we = wlo; wdata = wd;
    if (whi) exp_hi = wd;
    if (wlo) exp_lo = wd;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    OP = 2'($urandom); A = $urandom; B = $urandom;
    if (!dz) begin
      for (int k = 0; k < 33; k++) begin
        check("busy_status", status(), 32'h4);
        check("busy_hi", HI, exp_hi);
        check("busy_lo", LO, exp_lo);
        if (junk) begin
          start = 1'($urandom); hi_we = 1'($urandom); lo_we = 1'($urandom);
          wdata = $urandom; OP = 2'($urandom); B = 32'($urandom_range(0, 1));
        end
        tick();
      end
      exp_hi = rh;
      exp_lo = rl;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("done_status", status(), dz ? 32'h3 : 32'h2);
    check("done_hi", HI, exp_hi);
    check("done_lo", LO, exp_lo);
  endtask

  task automatic tick_idle();
    tick();
    check("idle_status", status(), 32'h0);
    check("idle_hi", HI, exp_hi);
    check("idle_lo", LO, exp_lo);
  endtask

  task automatic done_write(input logic whi, input logic wlo, input logic [31:0] wd);
    hi_we = whi; lo_we = wlo; wdata = wd;
    if (whi) exp_hi = wd;
    if (wlo) exp_lo = wd;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("dwr_status", status(), 32'h0);
    check("dwr_hi", HI, exp_hi);
    check("dwr_lo", LO, exp_lo);
  endtask

  initial begin
    bit seen_done;
    logic [1:0]  op;
    logic [31:0] a, b;

    #1;
    check("rst_status", status(), 32'h0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick_idle();

    hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    hi_we = 1'b0;
    exp_hi = 32'hCAFE_F00D;
    check("mthi", HI, 32'hCAFE_F00D);

    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b0);
    check("multu_max_hi", HI, 32'hFFFF_FFFE);
    check("multu_max_lo", LO, 32'h0000_0001);
    tick_idle();

    do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 32'd0, 1'b0);
    check("mult_neg_hi", HI, 32'hFFFF_FFFF);
    check("mult_neg_lo", LO, 32'hFFFF_FFF1);
    tick_idle();

    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0);
    check("div_neg_lo", LO, 32'hFFFF_FFFD);
    check("div_neg_hi", HI, 32'hFFFF_FFFF);
    // Back-to-back start from DONE.
    do_op(2'd3, 32'd7, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);
    tick_idle();

    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b0);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0);
    tick_idle();

    hi_we = 1'b1; wdata = 32'h1234;
    tick();
    hi_we = 1'b0;
    exp_hi = 32'h1234;
    do_op(2'd3, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    check("divz_hi", HI, 32'h1234);
    tick_idle();

    // Start/writes hammered while busy must be ignored.
    do_op(2'd1, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0, 1'b1);
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd42);
    // Write in DONE overwrites the fresh result.
    done_write(1'b1, 1'b0, 32'hDEAD_BEEF);
    check("dwr_const", HI, 32'hDEAD_BEEF);

    // Write on the start edge lands now; the result overwrites later.
    do_op(2'd1, 32'd3, 32'd4, 1'b1, 1'b1, 32'h5555_AAAA, 1'b0);
    check("wst_lo", LO, 32'd12);
    tick_idle();
    // Divide-by-zero start with a same-edge write keeps the written value.
    do_op(2'd2, 32'd9, 32'd0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0);
    check("wst_dz_lo", LO, 32'h0BAD_F00D);
    tick_idle();

    // Reset in the middle of an op.
    start = 1'b1; OP = 2'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    repeat (9) tick();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_status", status(), 32'h0);
    check("mid_rst_hi", HI, 32'd0);
    check("mid_rst_lo", LO, 32'd0);
    tick();
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    check("mid_rst_quiet", 32'(seen_done), 32'd0);
    check("mid_rst_hi2", HI, 32'd0);

    do_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0);
    check("post_rst_lo", LO, 32'd14);
    tick_idle();

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      do_op(op, a, b, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            $urandom, 1'($urandom));
      case ($urandom_range(0, 2))
        0: tick_idle();
        1: done_write(1'($urandom), 1'($urandom), $urandom);
        default: ;
      endcase
    end
    tick_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
